// File: rtl/ps2_key_gen_if.sv
// ps2_key event bus: key word plus its strobe and the frame-error pulse.
// The generator drives it (master); the keyboard decoder consumes it (slave).
interface ps2_key_gen_if;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  modport master (output ps2_key, output key_strobe, output frame_err);
  modport slave  (input  ps2_key, input  key_strobe, input  frame_err);
endinterface

// File: rtl/ps2_key_gen.sv
// PS/2 keyboard receiver: filters the raw pins, deframes bytes, and turns
// E0/F0-prefixed scan codes into {toggle, pressed, extended, code} events.
module ps2_key_gen #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 24000
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_key_gen_if.master key
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          filt_clk, filt_flip, fall;
  logic [FW-1:0] filt_cnt;
  logic [TW-1:0] to_cnt;
  logic          timeout;

  state_t        state, state_nx;
  logic [7:0]    shreg, shreg_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic          par_bit, par_nx;
  logic          byte_ok, bad;

  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          ext, rel;
  logic [2:0]    skip;
  logic [10:0]   key_q;
  logic          strobe_q, err_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Level flips only once FILTER_LEN consecutive samples disagree with it.
  assign filt_flip = (clk_sync[1] != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && filt_clk;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= ~filt_clk;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // A falling edge in the terminal-count cycle suppresses the timeout.
  assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                              to_cnt <= '0;
    else if (fall || timeout || state == ST_IDLE) to_cnt <= '0;
    else                                       to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_nx;
      par_bit <= par_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    bit_nx   = bit_cnt;
    par_nx   = par_bit;
    byte_ok  = 1'b0;
    bad      = 1'b0;
    if (timeout) begin
      state_nx = ST_IDLE;
    end else if (fall) begin
      case (state)
        ST_IDLE: begin
          if (!dat_sync[1]) begin
            state_nx = ST_DATA;
            bit_nx   = '0;
          end
        end
        ST_DATA: begin
          shreg_nx = {dat_sync[1], shreg[7:1]};
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = ST_PARITY;
        end
        ST_PARITY: begin
          par_nx   = dat_sync[1];
          state_nx = ST_STOP;
        end
        ST_STOP: begin
          state_nx = ST_IDLE;
          if (dat_sync[1] && (^shreg ^ par_bit)) byte_ok = 1'b1;
          else                                   bad     = 1'b1;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      byte_vld <= 1'b0;
      byte_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      byte_vld <= byte_ok;
      err_q    <= bad | timeout;
      if (byte_ok) byte_q <= shreg;
    end
  end

  // Byte interpretation runs one cycle behind deframing; a bad frame or
  // timeout can never coincide with byte_vld since the FSM is then in IDLE.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= '0;
      strobe_q <= 1'b0;
      ext      <= 1'b0;
      rel      <= 1'b0;
      skip     <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (bad || timeout) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (byte_vld) begin
        if (skip != '0) begin
          skip <= skip - 3'd1;
        end else begin
          case (byte_q)
            8'hE1: begin
              skip <= 3'd7;
              ext  <= 1'b0;
              rel  <= 1'b0;
            end
            8'hE0: ext <= 1'b1;
            8'hF0: rel <= 1'b1;
            8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'h00, 8'hFF: begin
              ext <= 1'b0;
              rel <= 1'b0;
            end
            default: begin
              key_q    <= {~key_q[10], ~rel, ext, byte_q};
              strobe_q <= 1'b1;
              ext      <= 1'b0;
              rel      <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign key.ps2_key    = key_q;
  assign key.key_strobe = strobe_q;
  assign key.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_gen.sv
// Directed PS/2 frames with hand-computed ps2_key words; a monitor process
// pops expected events whenever key_strobe or frame_err fires.
module tb_ps2_key_gen;
  localparam int unsigned TO_CYC = 2000;
  localparam int unsigned HALF   = 20;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_key_gen_if key_if ();

  ps2_key_gen #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .key     (key_if)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int n_strobe = 0;
  logic [10:0] exp_key_q[$];
  int          exp_err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [10:0] e;
    int tag;
    forever begin
      @(negedge clk_sys);
      if (key_if.key_strobe === 1'b1) begin
        n_strobe++;
        if (exp_key_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_strobe: got ps2_key %0h expected no event", key_if.ps2_key);
        end else begin
          e = exp_key_q.pop_front();
          check("ps2_key", 32'(key_if.ps2_key), 32'(e));
        end
      end
      if (key_if.frame_err === 1'b1) begin
        if (exp_err_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          tag = exp_err_q.pop_front();
          check($sformatf("frame_err#%0d", tag), 32'(key_if.frame_err), 32'd1);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic par_ok, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~^b : ^b);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send_good(input logic [7:0] b);
    send(b, 1'b1, 1'b1);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    ps2_dat = 1'b1;
  endtask

  initial begin
    int s0;
    wait_cyc(5);
    check("reset_key", 32'(key_if.ps2_key), 32'h0);
    check("reset_strobe", 32'(key_if.key_strobe), 32'h0);
    check("reset_err", 32'(key_if.frame_err), 32'h0);
    reset_n = 1'b1;
    wait_cyc(20);

    exp_key_q.push_back(11'h629);
    send_good(8'h29);

    s0 = n_strobe;
    send_good(8'hF0);
    check("f0_no_strobe", 32'(n_strobe), 32'(s0));
    exp_key_q.push_back(11'h029);
    send_good(8'h29);

    exp_key_q.push_back(11'h775);
    send_good(8'hE0); send_good(8'h75);
    exp_key_q.push_back(11'h175);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);

    exp_err_q.push_back(1);
    send(8'h1C, 1'b0, 1'b1);
    check("hold_after_parity_err", 32'(key_if.ps2_key), 32'h175);
    exp_key_q.push_back(11'h61C);
    send_good(8'h1C);

    exp_err_q.push_back(2);
    send(8'h1C, 1'b1, 1'b0);
    check("hold_after_stop_err", 32'(key_if.ps2_key), 32'h61C);

    exp_err_q.push_back(3);
    send_partial(8'h16, 4);
    wait_cyc(TO_CYC + 100);
    check("timeout_err_seen", 32'(exp_err_q.size()), 32'd0);
    exp_key_q.push_back(11'h216);
    send_good(8'h16);

    s0 = n_strobe;
    send_good(8'hE1); send_good(8'h14); send_good(8'h77); send_good(8'hE1);
    send_good(8'hF0); send_good(8'h14); send_good(8'hF0); send_good(8'h77);
    send_good(8'hFA); send_good(8'hAA);
    check("pause_no_strobe", 32'(n_strobe), 32'(s0));
    exp_key_q.push_back(11'h62E);
    send_good(8'h2E);
    exp_key_q.push_back(11'h22E);
    send_good(8'h2E);

    send_partial(8'h55, 3);
    reset_n = 1'b0;
    wait_cyc(3);
    check("midreset_key", 32'(key_if.ps2_key), 32'h0);
    check("midreset_strobe", 32'(key_if.key_strobe), 32'h0);
    check("midreset_err", 32'(key_if.frame_err), 32'h0);
    ps2_clk = 1'b1;
    wait_cyc(HALF);
    reset_n = 1'b1;
    wait_cyc(2 * HALF);
    exp_key_q.push_back(11'h629);
    send_good(8'h29);

    for (int i = 0; i < 200 && (exp_key_q.size() != 0 || exp_err_q.size() != 0); i++)
      wait_cyc(1);
    while (exp_key_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_strobe: got no event expected ps2_key %0h", exp_key_q.pop_front());
    end
    while (exp_err_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL missing_frame_err#%0d: got 0 expected 1", exp_err_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
